cpu_sram_like_bridge: RTL and testbench
=======================================

Name: cpu_sram_like_bridge

Overview:
- Converts one CPU SRAM-style port (single-cycle enable/write-enable/address/data) into an sram-like handshake bus (req/addr_ok/data_ok) with variable latency.
- Drives a stall back to the pipeline until each access completes.
- Supports exception flush while an access is in flight by discarding stale responses.
- Instantiated twice under the CPU top, once for instruction fetch and once for data, between the core and the bus arbiter.

Parameters:
- ADDR_W, 32, width of CPU and bus addresses.
- DISCARD_DEPTH, 2, maximum number of flushed, still-outstanding responses tracked. Minimum 1.
- READ_SIZE, 2, bus_size value driven for reads (2 = word).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- resetn  input  1  reset, asynchronous, active-low.
- cpu_en  input  1  CPU access request; held stable while cpu_stall=1.
- cpu_wen  input  4  byte write enables; 0 = read.
- cpu_addr  input  ADDR_W  access address (virtual).
- cpu_wdata  input  32  write data.
- cpu_flush  input  1  exception flush; abandons the current access.
- cpu_rdata  output  32  read data, valid in the completion cycle.
- cpu_stall  output  1  pipeline stall.
- bus_req  output  1  sram-like request.
- bus_wr  output  1  1 = write.
- bus_size  output  2  0 = byte, 1 = half, 2 = word.
- bus_addr  output  ADDR_W  physical address.
- bus_wdata  output  32  write data.
- bus_addr_ok  input  1  request accepted.
- bus_data_ok  input  1  response, in order.
- bus_rdata  input  32  response read data.
- busy  output  1  state != IDLE or discard_cnt != 0.

Behaviour:
- Reset (async, resetn=0): state=IDLE, discard_cnt=0, cancel=0, request regs=0, rdata_buf=0.
  - bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0, cpu_rdata=0, busy=0.
  - cpu_stall forced 0 while resetn=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If cpu_en & !cpu_flush & discard_cnt<DISCARD_DEPTH: capture wen/addr/wdata into request regs, go to REQ.
  - cpu_stall = cpu_en.
- REQ:
  - bus_req=1; bus outputs come from request regs only, stable until addr_ok.
  - On bus_addr_ok: go to WAIT, or to IDLE with discard_cnt+1 if cancel=1.
  - cpu_flush in REQ sets cancel. bus_req is never withdrawn before addr_ok.
  - cpu_stall = 1 if cancel=0, else cpu_en.
- WAIT:
  - bus_data_ok with discard_cnt==0 captures bus_rdata into rdata_buf and goes to DONE.
  - cpu_flush goes to IDLE with discard_cnt+1.
  - flush + data_ok in the same cycle: drop the response, go to IDLE, discard_cnt unchanged.
  - cpu_stall=1.
- DONE:
  - cpu_stall=0; cpu_rdata=rdata_buf for exactly this cycle.
  - Always goes to IDLE next cycle. A flush here is ignored.
- Discard counter:
  - Any bus_data_ok while discard_cnt>0 decrements it and is ignored, in any state.
  - Responses are in order, so discarded responses always precede the live one.
  - Increment and decrement in the same cycle: net unchanged.
  - While discard_cnt==DISCARD_DEPTH, no new request issues (stays IDLE, stalls).
- Size mapping:
  - 1111 → 2.
  - 0011/1100 → 1.
  - One-hot → 0.
  - 0000 → READ_SIZE, bus_wr=0.
  - Any other pattern → 2.
  - bus_wr = |wen.
- Minimum latency: IDLE→REQ 1 cycle; addr_ok in the first REQ cycle; data_ok the next cycle; DONE one cycle later. This gives 3 stalled cycles plus 1 completion cycle.
- bus_data_ok in IDLE/REQ/DONE with discard_cnt==0 is a protocol error and is ignored.

Optional Feature:
- Macro BRIDGE_FIXED_MMU_EN.
- When defined: bus_addr applies fixed mapping.
  - kseg0/kseg1 (addr[31:30]==2'b10): addr[31:29] cleared to 0.
  - Otherwise: passed through unchanged.
- When undefined: bus_addr = captured address unchanged.
- Translation is purely combinational on the request reg and adds no latency.

Test Plan:
- Read at 0xBFC00000, addr_ok on first REQ cycle, data_ok next cycle, rdata 0x3C1D0001 → cpu_stall high 3 cycles, cpu_rdata=0x3C1D0001 in DONE, bus_size=2, bus_wr=0; with BRIDGE_FIXED_MMU_EN bus_addr=0x1FC00000, else 0xBFC00000.
- Byte write wen=0100, addr 0x80000002, data 0x00AB0000, addr_ok delayed 4 cycles → bus_req held 4 cycles with constant outputs, bus_size=0, bus_wr=1; completes after data_ok.
- Flush during WAIT, then new read 0x1000, two data_ok (0xDEAD, 0x1234) → first dropped (discard_cnt 1→0), cpu_rdata=0x1234.
- Flush during REQ before addr_ok → bus_req remains until addr_ok, then IDLE with discard_cnt=1; the following data_ok is ignored; busy drops after it.
- Two successive flushes with DISCARD_DEPTH=2, no data_ok → third cpu_en stays IDLE with cpu_stall=1 until one data_ok arrives, then issues.
- resetn asserted in WAIT → all outputs 0 immediately; after release a pending data_ok is ignored in IDLE, no state change.

Source files
------------

// File: rtl/cpu_sram_like_bridge_if.sv
// cpu_sram_like_bridge_if: sram-like bus between the bridge (master) and the bus arbiter (slave).
interface cpu_sram_like_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/cpu_sram_like_bridge.sv
// cpu_sram_like_bridge: CPU SRAM port to sram-like req/addr_ok/data_ok bus, with stall and flush discard.
// Define BRIDGE_FIXED_MMU_EN to map kseg0/kseg1 addresses to physical on bus_addr.
module cpu_sram_like_bridge #(
    parameter int         ADDR_W        = 32,
    parameter int         DISCARD_DEPTH = 2,
    parameter logic [1:0] READ_SIZE     = 2'd2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cpu_en,
    input  logic [3:0]             cpu_wen,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [31:0]            cpu_wdata,
    input  logic                   cpu_flush,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_stall,
    output logic                   busy,
    cpu_sram_like_bridge_if.master bus
);
    localparam int CW = $clog2(DISCARD_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic              cancel_q, cancel_d;
    logic [3:0]        wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d, phys;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic              room, drop, live_ok, kill, req;
    logic [1:0]        size;

    assign room    = discard_q < CW'(DISCARD_DEPTH);
    assign drop    = bus.bus_data_ok && discard_q != '0;
    assign live_ok = bus.bus_data_ok && discard_q == '0;
    assign req     = state_q == REQ;

    // Non-contiguous enable patterns fall back to a word access.
    assign size = (wen_q == 4'b0000) ? READ_SIZE :
                  (wen_q == 4'b0011 || wen_q == 4'b1100) ? 2'd1 :
                  ((wen_q & (wen_q - 4'd1)) == 4'd0) ? 2'd0 : 2'd2;

`ifdef BRIDGE_FIXED_MMU_EN
    assign phys = (addr_q[ADDR_W-1 -: 2] == 2'b10) ? {3'b000, addr_q[ADDR_W-4:0]} : addr_q;
`else
    assign phys = addr_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            discard_q <= '0;
            cancel_q  <= 1'b0;
            wen_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            cancel_q  <= cancel_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // A flush coinciding with addr_ok counts as cancelled: the response is already owed.
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        kill     = 1'b0;
        case (state_q)
            IDLE: if (cpu_en && !cpu_flush && room) begin
                state_d = REQ;
                wen_d   = cpu_wen;
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
            end
            REQ: if (bus.bus_addr_ok) begin
                state_d  = (cancel_q || cpu_flush) ? IDLE : WAIT;
                kill     = cancel_q || cpu_flush;
                cancel_d = 1'b0;
            end else if (cpu_flush) begin
                cancel_d = 1'b1;
            end
            WAIT: if (cpu_flush) begin
                state_d = IDLE;
                kill    = !live_ok;
            end else if (live_ok) begin
                state_d = DONE;
                rdata_d = bus.bus_rdata;
            end
            default: state_d = IDLE;
        endcase
        discard_d = discard_q + CW'(kill) - CW'(drop);
    end

    always_comb begin
        bus.bus_req   = req;
        bus.bus_wr    = req && wen_q != 4'd0;
        bus.bus_size  = req ? size : 2'd0;
        bus.bus_addr  = req ? phys : '0;
        bus.bus_wdata = req ? wdata_q : 32'd0;
        cpu_rdata     = (state_q == DONE) ? rdata_q : 32'd0;
        cpu_stall     = resetn && ((state_q == IDLE) ? cpu_en :
                                   (state_q == REQ)  ? (cancel_q ? cpu_en : 1'b1) :
                                   (state_q == WAIT));
        busy          = state_q != IDLE || discard_q != '0;
    end
endmodule

// File: tb/tb_cpu_sram_like_bridge.sv
// tb_cpu_sram_like_bridge: vector table, flush/reset corner sequences and a randomized run
// checked against a transaction-level model of outstanding bus responses.
`timescale 1ns/1ps
module tb_cpu_sram_like_bridge;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 2;
`ifdef BRIDGE_FIXED_MMU_EN
    localparam bit MMU = 1'b1;
`else
    localparam bit MMU = 1'b0;
`endif

    logic        clk = 1'b0, resetn = 1'b0, cpu_en = 1'b0, cpu_flush = 1'b0;
    logic [3:0]  cpu_wen = 4'd0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, busy;
    int          n_tests = 0, n_fail = 0;

    cpu_sram_like_bridge_if #(.ADDR_W(ADDR_W)) bif ();

    cpu_sram_like_bridge #(.ADDR_W(ADDR_W), .DISCARD_DEPTH(DEPTH), .READ_SIZE(2'd2)) dut (
        .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .busy(busy), .bus(bif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] va, pa_mmu, wdata, rdata;
        int          dly;
        logic [1:0]  size;
        logic        wr;
    } vec_t;
    vec_t tbl [10];

    bit          q[$];
    bit          cur_active = 0, live_out = 0, dead_pending = 0, done_next = 0;
    int          gap = 0, age = 0;
    logic [3:0]  r_wen = 4'd0;
    logic [31:0] r_addr = 32'd0, r_wdata = 32'd0, exp_rd = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_size(input logic [3:0] w);
        int n = $countones(w);
        return (w == 4'd0) ? 2'd2 : (n == 1) ? 2'd0 : (w == 4'b0011 || w == 4'b1100) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
        return (MMU && a[31:30] == 2'b10) ? (a & 32'h1FFF_FFFF) : a;
    endfunction

    // One complete access: addr_ok after v.dly refused REQ cycles, data_ok the cycle after.
    task automatic access(input vec_t v, input string tag);
        int          stalls = 0, reqs = 0;
        bit          done = 0, pend = 0, nxt_pend;
        logic [31:0] rd = 32'd0;
        cpu_en = 1'b1; cpu_wen = v.wen; cpu_addr = v.va; cpu_wdata = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bif.bus_req) begin
                reqs++;
                chk({tag, " addr"}, bif.bus_addr, MMU ? v.pa_mmu : v.va);
                chk({tag, " size"}, 32'(bif.bus_size), 32'(v.size));
                chk({tag, " wr"}, 32'(bif.bus_wr), 32'(v.wr));
                chk({tag, " wdata"}, bif.bus_wdata, v.wdata);
            end
            if (cpu_stall) stalls++;
            else begin
                done = 1;
                rd = cpu_rdata;
            end
            bif.bus_addr_ok = bif.bus_req && reqs > v.dly;
            bif.bus_data_ok = pend;
            bif.bus_rdata   = v.rdata;
            nxt_pend = bif.bus_addr_ok;
            @(negedge clk);
            pend = nxt_pend;
        end
        cpu_en = 1'b0; bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " stall cycles"}, stalls, v.dly + 3);
        chk({tag, " req cycles"}, reqs, v.dly + 1);
        chk({tag, " rdata"}, rd, v.rdata);
    endtask

    task automatic flushed_access(input logic [31:0] a);
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = a;
        @(negedge clk); bif.bus_addr_ok = 1'b1;
        @(negedge clk); bif.bus_addr_ok = 1'b0; cpu_flush = 1'b1;
        @(negedge clk); cpu_flush = 1'b0; cpu_en = 1'b0;
    endtask

    // Model: q holds accepted-but-unanswered requests, 1 = belongs to the live CPU access.
    task automatic rand_cycle(input bit allow_new, input int pct);
        bit          flush, aok, dok, live_pop = 0;
        logic [31:0] rdv;
        if (!cur_active && allow_new) begin
            if (gap > 0) gap--;
            else begin
                cur_active = 1; age = 0;
                r_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
                r_addr  = $urandom;
                r_wdata = $urandom;
            end
        end
        cpu_en = cur_active; cpu_wen = r_wen; cpu_addr = r_addr; cpu_wdata = r_wdata;
        flush = allow_new && cur_active && !done_next && $urandom_range(0, 15) == 0;
        cpu_flush = flush;
        #1;
        if (!flush) chk("rnd stall", 32'(cpu_stall), 32'(cur_active && !done_next));
        if (done_next) chk("rnd rdata", cpu_rdata, exp_rd);
        dok = q.size() > 0 && $urandom_range(0, 99) < pct;
        aok = bif.bus_req && $urandom_range(0, 99) < pct;
        rdv = $urandom;
        bif.bus_data_ok = dok; bif.bus_addr_ok = aok; bif.bus_rdata = rdv;
        if (flush) begin
            if (live_out) begin
                foreach (q[i]) q[i] = 1'b0;
                live_out = 0;
            end else if (bif.bus_req) dead_pending = 1;
            cur_active = 0; gap = $urandom_range(0, 2);
        end
        if (dok && q.pop_front()) begin
            live_pop = 1; exp_rd = rdv; live_out = 0;
        end
        if (aok) begin
            if (dead_pending) begin
                q.push_back(1'b0); dead_pending = 0;
            end else begin
                chk("rnd issue owner", 32'(cur_active), 32'd1);
                chk("rnd addr", bif.bus_addr, exp_addr(r_addr));
                chk("rnd size", 32'(bif.bus_size), 32'(exp_size(r_wen)));
                chk("rnd wr", 32'(bif.bus_wr), 32'(r_wen != 4'd0));
                chk("rnd wdata", bif.bus_wdata, r_wdata);
                q.push_back(1'b1); live_out = 1;
            end
        end
        if (done_next) begin
            cur_active = 0; gap = $urandom_range(0, 2);
        end
        done_next = live_pop;
        if (cur_active) age++;
        if (age == 400) begin
            n_tests++; n_fail++;
            $display("FAIL rnd timeout: access pending %0d cycles, expected completion", age);
        end
        @(negedge clk);
        cpu_flush = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b0000, 32'hBFC00000, 32'h1FC00000, 32'h00000000, 32'h3C1D0001, 0, 2'd2, 1'b0};
        tbl[1] = '{4'b0100, 32'h80000002, 32'h00000002, 32'h00AB0000, 32'h11110001, 3, 2'd0, 1'b1};
        tbl[2] = '{4'b1111, 32'h00001000, 32'h00001000, 32'h12345678, 32'h22220002, 1, 2'd2, 1'b1};
        tbl[3] = '{4'b0011, 32'h9FC01234, 32'h1FC01234, 32'h0000BEEF, 32'h33330003, 0, 2'd1, 1'b1};
        tbl[4] = '{4'b1100, 32'hA0000010, 32'h00000010, 32'hCAFE0000, 32'h44440004, 2, 2'd1, 1'b1};
        tbl[5] = '{4'b0001, 32'hC0000040, 32'hC0000040, 32'h000000AA, 32'h55550005, 0, 2'd0, 1'b1};
        tbl[6] = '{4'b1000, 32'h7FFFFFFC, 32'h7FFFFFFC, 32'hBB000000, 32'h66660006, 1, 2'd0, 1'b1};
        tbl[7] = '{4'b0110, 32'h00000100, 32'h00000100, 32'h00CDEF00, 32'h77770007, 0, 2'd2, 1'b1};
        tbl[8] = '{4'b0101, 32'h80001000, 32'h00001000, 32'h00110022, 32'h88880008, 0, 2'd2, 1'b1};
        tbl[9] = '{4'b0010, 32'h00000200, 32'h00000200, 32'h0000CC00, 32'h99990009, 0, 2'd0, 1'b1};
        bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; bif.bus_rdata = 32'd0;
        cpu_en = 1'b1;
        @(negedge clk); #1;
        chk("reset stall", 32'(cpu_stall), 32'd0);
        chk("reset req", 32'(bif.bus_req), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rdata", cpu_rdata, 32'd0);
        chk("reset size", 32'(bif.bus_size), 32'd0);
        chk("reset addr", bif.bus_addr, 32'd0);
        cpu_en = 1'b0; resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) access(tbl[i], $sformatf("vec%0d", i));
        // flush in WAIT, then the stale response must be dropped
        cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h2000;
        @(negedge clk); bif.bus_addr_ok = 1'b1;
        @(negedge clk); bif.bus_addr_ok = 1'b0; cpu_flush = 1'b1; #1;
        chk("wflush stall", 32'(cpu_stall), 32'd1);
        @(negedge clk); cpu_flush = 1'b0; cpu_addr = 32'h1000; #1;
        chk("wflush busy", 32'(busy), 32'd1);
        chk("wflush new stall", 32'(cpu_stall), 32'd1);
        @(negedge clk); #1;
        chk("wflush req", 32'(bif.bus_req), 32'd1);
        chk("wflush addr", bif.bus_addr, 32'h1000);
        bif.bus_addr_ok = 1'b1;
        @(negedge clk); bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'hDEAD; #1;
        chk("wflush stale stall", 32'(cpu_stall), 32'd1);
        @(negedge clk); bif.bus_rdata = 32'h1234; #1;
        chk("wflush live stall", 32'(cpu_stall), 32'd1);
        @(negedge clk); bif.bus_data_ok = 1'b0; #1;
        chk("wflush done stall", 32'(cpu_stall), 32'd0);
        chk("wflush rdata", cpu_rdata, 32'h1234);
        @(negedge clk); cpu_en = 1'b0; #1;
        chk("wflush idle busy", 32'(busy), 32'd0);
        chk("wflush idle rdata", cpu_rdata, 32'd0);
        // flush in REQ: request stays up until accepted, its response is discarded
        @(negedge clk); cpu_en = 1'b1; cpu_addr = 32'h3000;
        @(negedge clk); cpu_flush = 1'b1; #1;
        chk("rflush req", 32'(bif.bus_req), 32'd1);
        chk("rflush stall", 32'(cpu_stall), 32'd1);
        @(negedge clk); cpu_flush = 1'b0; cpu_en = 1'b0; #1;
        chk("rflush req held", 32'(bif.bus_req), 32'd1);
        chk("rflush stall off", 32'(cpu_stall), 32'd0);
        chk("rflush addr", bif.bus_addr, 32'h3000);
        bif.bus_addr_ok = 1'b1;
        @(negedge clk); bif.bus_addr_ok = 1'b0; #1;
        chk("rflush req drop", 32'(bif.bus_req), 32'd0);
        chk("rflush busy", 32'(busy), 32'd1);
        bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h0BAD;
        @(negedge clk); bif.bus_data_ok = 1'b0; #1;
        chk("rflush busy clear", 32'(busy), 32'd0);
        chk("rflush no done", 32'(cpu_rdata), 32'd0);
        // discard counter full blocks new issue
        @(negedge clk);
        flushed_access(32'h4000);
        flushed_access(32'h5000);
        cpu_en = 1'b1; cpu_addr = 32'h6000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full stall", 32'(cpu_stall), 32'd1);
            chk("full no req", 32'(bif.bus_req), 32'd0);
            @(negedge clk);
        end
        bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h4444; #1;
        chk("full drain req", 32'(bif.bus_req), 32'd0);
        @(negedge clk); bif.bus_data_ok = 1'b0; #1;
        chk("full capture req", 32'(bif.bus_req), 32'd0);
        @(negedge clk); #1;
        chk("full issue req", 32'(bif.bus_req), 32'd1);
        chk("full issue addr", bif.bus_addr, 32'h6000);
        bif.bus_addr_ok = 1'b1;
        @(negedge clk); bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h5555; #1;
        chk("full stale stall", 32'(cpu_stall), 32'd1);
        @(negedge clk); bif.bus_rdata = 32'h6666; #1;
        chk("full live stall", 32'(cpu_stall), 32'd1);
        @(negedge clk); bif.bus_data_ok = 1'b0; #1;
        chk("full done stall", 32'(cpu_stall), 32'd0);
        chk("full rdata", cpu_rdata, 32'h6666);
        @(negedge clk); cpu_en = 1'b0; #1;
        chk("full busy clear", 32'(busy), 32'd0);
        // asynchronous reset while waiting for data
        @(negedge clk); cpu_en = 1'b1; cpu_addr = 32'h7000;
        @(negedge clk); bif.bus_addr_ok = 1'b1;
        @(negedge clk); bif.bus_addr_ok = 1'b0; #1;
        chk("rst wait stall", 32'(cpu_stall), 32'd1);
        resetn = 1'b0; #1;
        chk("rst stall", 32'(cpu_stall), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req", 32'(bif.bus_req), 32'd0);
        chk("rst rdata", cpu_rdata, 32'd0);
        @(negedge clk); resetn = 1'b1; cpu_en = 1'b0; bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h7777;
        @(negedge clk); bif.bus_data_ok = 1'b0; #1;
        chk("rst stray busy", 32'(busy), 32'd0);
        chk("rst stray stall", 32'(cpu_stall), 32'd0);
        chk("rst stray rdata", cpu_rdata, 32'd0);
        chk("rst stray req", 32'(bif.bus_req), 32'd0);
        @(negedge clk);
        access(tbl[0], "post-reset");
        // randomized traffic, then drain every outstanding response
        for (int c = 0; c < 4000; c++) rand_cycle(1'b1, 60);
        for (int c = 0; c < 80; c++) rand_cycle(1'b0, 100);
        cpu_en = 1'b0; bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; #1;
        chk("drain queue", q.size(), 32'd0);
        chk("drain access", 32'(cur_active), 32'd0);
        chk("drain pending", 32'(dead_pending), 32'd0);
        chk("drain busy", 32'(busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
